// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU scheduler slice: default operand width,
// command width, opcode constants, scheduler state encoding and an opcode
// legality helper.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_N_DEFAULT = 16;
  localparam int CMD_W         = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_NAND = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } sched_state_t;

  // Opcodes 12..15 are reserved and rejected by the scheduler.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_NOR);
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// ---------------------------------------------------------------------------
// alu_scheduler_if
// Bundles the two requester channels, the ALU datapath connection and the
// response channel of the ALU scheduler.
//   req0_*/req1_* : valid/ready request channels with cmd (5b) and a/b (N)
//   alu_*         : operands/command to the ALU, noop, 2N result and ovf
//   resp_*        : valid/ready response with id, 2N data, err, ovf
//   busy          : scheduler not idle
// Modports: slave  = scheduler side
//           master = environment side (requesters, ALU, response sink)
// ---------------------------------------------------------------------------
interface alu_scheduler_if
  import alu_pkg::*;
#(
  parameter int N = ALU_N_DEFAULT
);

  logic             req0_valid;
  logic             req0_ready;
  logic [CMD_W-1:0] req0_cmd;
  logic [N-1:0]     req0_a;
  logic [N-1:0]     req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [CMD_W-1:0] req1_cmd;
  logic [N-1:0]     req1_a;
  logic [N-1:0]     req1_b;

  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [CMD_W-1:0] alu_cmd;
  logic             alu_noop;
  logic [2*N-1:0]   alu_result;
  logic             alu_ovf;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [2*N-1:0]   resp_data;
  logic             resp_err;
  logic             resp_ovf;

  logic             busy;

  modport slave (
    input  req0_valid, req0_cmd, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_cmd, req1_a, req1_b,
    output req1_ready,
    output alu_a, alu_b, alu_cmd, alu_noop,
    input  alu_result, alu_ovf,
    output resp_valid, resp_id, resp_data, resp_err, resp_ovf,
    input  resp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_cmd, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_cmd, req1_a, req1_b,
    input  req1_ready,
    input  alu_a, alu_b, alu_cmd, alu_noop,
    output alu_result, alu_ovf,
    input  resp_valid, resp_id, resp_data, resp_err, resp_ovf,
    output resp_ready,
    input  busy
  );

endinterface

// File: rtl/alu_scheduler_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin arbiter, purely combinational.
//   valid0/valid1 : requests
//   last          : id of the requester granted last time
//   grant[1:0]    : one-hot grant (all zero when nothing is requesting)
// On a tie the requester that was not granted last wins.
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = last ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// ---------------------------------------------------------------------------
// alu_scheduler
// Accepts one operation at a time from two requesters (round-robin), drives
// it into an external multi-cycle ALU, waits EXEC_CYCLES and returns the
// result on a valid/ready response channel. Illegal opcodes and divide by
// zero are answered with an error response without touching the ALU.
// Ports:
//   clk : clock, rising edge
//   clr : synchronous active-low reset
//   bus : alu_scheduler_if.slave (requests, ALU connection, response, busy)
// Parameters: N operand width, EXEC_CYCLES issue-to-result cycles (1..15).
// Build option: ALU_SCHED_ACCUM_EN adds a 2N-bit accumulator; ops with
// cmd[4]=1 add their result into it and respond with the new sum.
// ---------------------------------------------------------------------------
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int N           = ALU_N_DEFAULT,
  parameter int EXEC_CYCLES = 1
) (
  input  logic           clk,
  input  logic           clr,
  alu_scheduler_if.slave bus
);

  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  sched_state_t     state_q;
  sched_state_t     state_d;

  logic             last_q;
  logic [1:0]       grant;
  logic             take;
  logic             sel_id;
  logic [CMD_W-1:0] sel_cmd;
  logic [N-1:0]     sel_a;
  logic [N-1:0]     sel_b;
  logic             sel_err;

  logic [CMD_W-1:0] cmd_q;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             exec_done;

  logic [2*N-1:0]   resp_data_q;
  logic             resp_err_q;
  logic             resp_ovf_q;
  logic             resp_id_q;

`ifdef ALU_SCHED_ACCUM_EN
  logic [2*N-1:0]   acc_q;
  logic [2*N-1:0]   acc_sum;
`endif

  // Operations the ALU must never see: reserved opcodes and divide by zero.
  function automatic logic req_is_error(input logic [CMD_W-1:0] cmd,
                                        input logic [N-1:0]     b);
    return !op_is_legal(cmd[3:0]) || ((cmd[3:0] == OP_DIV) && (b == '0));
  endfunction

  rr_arbiter2 u_arb (
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .last   (last_q),
    .grant  (grant)
  );

  assign take      = (state_q == IDLE) && (grant != 2'b00);
  assign sel_id    = grant[1];
  assign sel_cmd   = sel_id ? bus.req1_cmd : bus.req0_cmd;
  assign sel_a     = sel_id ? bus.req1_a   : bus.req0_a;
  assign sel_b     = sel_id ? bus.req1_b   : bus.req0_b;
  assign sel_err   = req_is_error(sel_cmd, sel_b);
  assign exec_done = (state_q == EXEC) && (cnt_q == '0);

`ifdef ALU_SCHED_ACCUM_EN
  assign acc_sum = acc_q + bus.alu_result;
`endif

  // Next state and combinational outputs
  always_comb begin
    state_d        = state_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.alu_noop   = 1'b1;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.alu_cmd    = '0;
    bus.resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req0_ready = grant[0];
        bus.req1_ready = grant[1];
        if (take) begin
          state_d = sel_err ? RESP : LOAD;
        end
      end
      LOAD: begin
        bus.alu_noop = 1'b0;
        bus.alu_a    = a_q;
        bus.alu_b    = b_q;
        bus.alu_cmd  = cmd_q;
        state_d      = EXEC;
      end
      EXEC: begin
        bus.alu_noop = 1'b0;
        bus.alu_a    = a_q;
        bus.alu_b    = b_q;
        bus.alu_cmd  = cmd_q;
        if (cnt_q == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.resp_id   = resp_id_q;
  assign bus.resp_data = resp_data_q;
  assign bus.resp_err  = resp_err_q;
  assign bus.resp_ovf  = resp_ovf_q;

  // Control state, response registers and accumulator
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      resp_id_q   <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      resp_ovf_q  <= 1'b0;
`ifdef ALU_SCHED_ACCUM_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q <= state_d;

      // The count is armed while operands sit in LOAD so that the first
      // EXEC cycle already sees EXEC_CYCLES-1.
      if (state_q == LOAD) begin
        cnt_q <= CNT_LOAD;
      end else if ((state_q == EXEC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (take) begin
        resp_id_q <= sel_id;
        if (sel_err) begin
          resp_data_q <= '0;
          resp_err_q  <= 1'b1;
          resp_ovf_q  <= 1'b0;
        end
      end

      if (exec_done) begin
        resp_err_q <= 1'b0;
        resp_ovf_q <= bus.alu_ovf;
`ifdef ALU_SCHED_ACCUM_EN
        if (cmd_q[4]) begin
          acc_q       <= acc_sum;
          resp_data_q <= acc_sum;
        end else begin
          resp_data_q <= bus.alu_result;
        end
`else
        resp_data_q <= bus.alu_result;
`endif
      end

      if ((state_q == RESP) && bus.resp_ready) begin
        last_q <= resp_id_q;
      end
    end
  end

  // Captured operation, held for the whole LOAD/EXEC window
  always_ff @(posedge clk) begin
    if (take) begin
      cmd_q <= sel_cmd;
      a_q   <= sel_a;
      b_q   <= sel_b;
    end
  end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter N, default 16, operand width.
REQ-002 Parameter EXEC_CYCLES, default 1, cycles from operand issue to valid alu_result (legal 1..15).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 clr  in  1  reset, synchronous, active-low.
REQ-005 req0_valid / req1_valid  in  1  requester 0/1 has an operation pending.
REQ-006 req0_ready / req1_ready  out  1  operation accepted this cycle (valid && ready).
REQ-007 req0_cmd / req1_cmd  in  5  opcode; bits[3:0] op, bit[4] accumulate flag.
REQ-008 req0_a, req0_b, req1_a, req1_b  in  N  operands.
REQ-009 alu_a, alu_b  out  N  operands driven to ALU datapath.
REQ-010 alu_cmd  out  5  opcode driven to ALU.
REQ-011 alu_noop  out  1  high = ALU idle, holds its registers.
REQ-012 alu_result  in  2N  ALU result; alu_ovf  in  1  ALU overflow.
REQ-013 resp_valid  out  1; resp_ready  in  1; resp_id  out  1 (requester); resp_data  out  2N; resp_err  out  1; resp_ovf  out  1.
REQ-014 busy  out  1  high whenever state != IDLE.

Function
REQ-015 Opcodes bits[3:0]: 0 ADD, 1 SUB, 2 MULT, 3 DIV, 4 SLL, 5 SRL, 6 AND, 7 OR, 8 XOR, 9 NOT, 10 NAND, 11 NOR; 12-15 illegal.
REQ-016 FSM states IDLE, LOAD, EXEC, RESP.
REQ-017 IDLE: if any valid, assert exactly one ready combinationally, capture cmd/a/b/id, go LOAD; ready low in all other states.
REQ-018 Arbitration round-robin: both valid -> grant requester != last granted; last-granted pointer resets to 1 (requester 0 wins first tie).
REQ-019 LOAD: alu_noop=0, alu_a/alu_b/alu_cmd = captured values for one cycle, go EXEC.
REQ-020 EXEC: counter loads EXEC_CYCLES-1, alu_noop=0, operands held; at count 0 capture alu_result into resp_data, alu_ovf into resp_ovf, go RESP.
REQ-021 Illegal opcode or DIV with b=0: skip LOAD/EXEC, go IDLE->RESP directly with resp_err=1, resp_data=0, alu_noop stays 1.
REQ-022 RESP: resp_valid=1; resp_id/data/err/ovf stable while resp_ready=0; on resp_ready=1 go IDLE next cycle, pointer updated to resp_id.
REQ-023 New request can be accepted no earlier than the cycle after the RESP handshake; minimum legal-op turnaround = EXEC_CYCLES+3 cycles.
REQ-024 alu_noop=1 and alu_a/alu_b/alu_cmd=0 in IDLE and RESP.
REQ-025 Valid dropping while not ready: no effect; a request is only taken on valid && ready.

Reset
REQ-026 clr=0 at a rising edge: state IDLE, resp_valid 0, resp_data 0, resp_err 0, resp_ovf 0, resp_id 0, alu_noop 1, alu operands/cmd 0, counter 0, pointer 1, accumulator 0.
REQ-027 clr mid-operation aborts the operation; no response is ever produced for it.

Configuration
REQ-028 Macro ALU_SCHED_ACCUM_EN defined: 2N-bit accumulator; legal op with cmd[4]=1 adds alu_result to accumulator (wrap modulo 2^2N) at EXEC exit, resp_data = new accumulator value; illegal/err ops leave it unchanged.
REQ-029 Macro undefined: no accumulator; cmd[4] passed to alu_cmd but ignored by scheduler; resp_data = alu_result.

Structure
REQ-030 Shared package alu_pkg: opcode constants, state enum, default N.
REQ-031 Sub-module rr_arbiter2: two valids + pointer in, one-hot grant out, purely combinational.

Verification
REQ-032 req0 ADD a=17 b=15, EXEC_CYCLES=1, resp_ready=1 -> resp_id 0, resp_data 32, resp_err 0, 4 cycles accept-to-RESP-handshake.
REQ-033 req0 and req1 valid same cycle after reset -> req0 served first, then req1; repeated ties alternate 0,1,0,1.
REQ-034 req1 DIV a=100 b=0 -> no alu_noop=0 cycle, resp_err 1, resp_data 0.
REQ-035 resp_ready held 0 for 5 cycles -> resp_valid and payload stable, both ready low, busy 1.
REQ-036 clr=0 during EXEC -> next cycle IDLE, resp_valid 0, alu_noop 1; subsequent request served normally.
REQ-037 With ALU_SCHED_ACCUM_EN: MULT 3*4 cmd[4]=1 then ADD 1+1 cmd[4]=1 -> resp_data 12 then 14.
